call_stack: RTL and testbench

Parametrised return-address stack for the MUSA instruction-fetch stage. It holds PC values pushed by CALL and returns them on RET, with configurable address width and depth. It supports simultaneous push/pop (return-then-call), sticky overflow/underflow flags with explicit clear, and an optional circular mode that overwrites the oldest entry instead of rejecting a push when full. The IF PC mux consumes `pop_addr`/`pop_valid`; the control unit drives `push`/`pop` and monitors the error flags.

---
 rtl/musa_pkg.sv | 18 +
 rtl/call_stack_if.sv | 38 +++
 rtl/call_stack_ptr.sv | 62 ++++++
 rtl/call_stack.sv | 113 +++++++++++
 tb/tb_call_stack.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/musa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : musa_pkg                                                   |
// | Shared MUSA fetch-stage constants and types.                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package musa_pkg;
    localparam int PC_W       = 13;
    localparam int CALL_DEPTH = 8;

    typedef logic [PC_W-1:0] pc_t;

    // Width needed to count 0..depth inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage
`default_nettype wire

// File: rtl/call_stack_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : call_stack_if                                            |
// | Push/pop request and status bundle of the return-address stack.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface call_stack_if
    import musa_pkg::*;
#(
    parameter int ADDR_W = PC_W,
    parameter int DEPTH  = CALL_DEPTH
) ();
    localparam int LVL_W = lvl_width(DEPTH);

    logic              push;
    logic [ADDR_W-1:0] push_addr;
    logic              pop;
    logic              err_clr;
    logic [ADDR_W-1:0] pop_addr;
    logic              pop_valid;
    logic [ADDR_W-1:0] top;
    logic [LVL_W-1:0]  level;
    logic              empty;
    logic              full;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, push_addr, pop, err_clr,
        input  pop_addr, pop_valid, top, level, empty, full, overflow, underflow
    );

    modport slave (
        input  push, push_addr, pop, err_clr,
        output pop_addr, pop_valid, top, level, empty, full, overflow, underflow
    );
endinterface
`default_nettype wire

// File: rtl/call_stack_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : call_stack_ptr                                             |
// | Modulo-DEPTH write pointer and level tracking for call_stack.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module call_stack_ptr
    import musa_pkg::*;
#(
    parameter int  DEPTH   = CALL_DEPTH,
    parameter bit  WRAP_EN = 1'b0,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LVL_W   = lvl_width(DEPTH)
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire logic             full,
    input  wire logic             empty,
    output logic      [PTR_W-1:0] wp,
    output logic      [PTR_W-1:0] top_idx,
    output logic      [LVL_W-1:0] level
);
    logic [PTR_W-1:0] wp_q, wp_d, wp_inc, wp_dec;
    logic [LVL_W-1:0] level_q, level_d;

    // DEPTH need not be a power of two, so wrap explicitly.
    assign wp_inc = (wp_q == PTR_W'(DEPTH - 1)) ? '0 : wp_q + PTR_W'(1);
    assign wp_dec = (wp_q == '0) ? PTR_W'(DEPTH - 1) : wp_q - PTR_W'(1);

    always_comb begin
        wp_d    = wp_q;
        level_d = level_q;
        if (push && !pop) begin
            if (!full) begin
                wp_d    = wp_inc;
                level_d = level_q + LVL_W'(1);
            end else if (WRAP_EN) begin
                wp_d = wp_inc;
            end
        end else if (pop && !push && !empty) begin
            wp_d    = wp_dec;
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q    <= '0;
            level_q <= '0;
        end else begin
            wp_q    <= wp_d;
            level_q <= level_d;
        end
    end

    assign wp      = wp_q;
    assign top_idx = wp_dec;
    assign level   = level_q;
endmodule
`default_nettype wire

// File: rtl/call_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : call_stack                                                 |
// | Return-address stack with push/pop bypass and sticky error flags.    |
// | Define CALL_STACK_WRAP_EN to overwrite the oldest entry when full.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module call_stack
    import musa_pkg::*;
#(
    parameter int ADDR_W = PC_W,
    parameter int DEPTH  = CALL_DEPTH
) (
    input  wire logic     clk,
    input  wire logic     reset,
    call_stack_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = lvl_width(DEPTH);
`ifdef CALL_STACK_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wp, top_idx, mem_waddr;
    logic [LVL_W-1:0]  level;
    logic              empty, full, mem_we;
    logic [ADDR_W-1:0] pop_addr_q, pop_addr_d;
    logic              pop_valid_q, pop_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    assign empty = (level == '0);
    assign full  = (level == LVL_W'(DEPTH));

    call_stack_ptr #(
        .DEPTH   (DEPTH),
        .WRAP_EN (WRAP_EN)
    ) u_ptr (
        .clk     (clk),
        .reset   (reset),
        .push    (bus.push),
        .pop     (bus.pop),
        .full    (full),
        .empty   (empty),
        .wp      (wp),
        .top_idx (top_idx),
        .level   (level)
    );

    // Return-then-call replaces the top entry in place.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wp;
        if (bus.push && bus.pop) begin
            mem_we    = !empty;
            mem_waddr = top_idx;
        end else if (bus.push) begin
            mem_we = !full || WRAP_EN;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= bus.push_addr;
        end
    end

    always_comb begin
        pop_addr_d  = pop_addr_q;
        pop_valid_d = 1'b0;
        if (bus.pop) begin
            if (!empty) begin
                pop_addr_d  = mem_q[top_idx];
                pop_valid_d = 1'b1;
            end else if (bus.push) begin
                pop_addr_d  = bus.push_addr;
                pop_valid_d = 1'b1;
            end
        end
        // A new error wins over a same-cycle clear.
        overflow_d  = (bus.push && !bus.pop && full) ||
                      (overflow_q && !bus.err_clr);
        underflow_d = (bus.pop && !bus.push && empty) ||
                      (underflow_q && !bus.err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_addr_q  <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            pop_addr_q  <= pop_addr_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.pop_addr  = pop_addr_q;
    assign bus.pop_valid = pop_valid_q;
    assign bus.top       = mem_q[top_idx];
    assign bus.level     = level;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule
`default_nettype wire

// File: tb/tb_call_stack.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_call_stack                                              |
// | Directed self-checking bench for call_stack (DEPTH 8 and DEPTH 5).   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_call_stack;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    call_stack_if #(.ADDR_W(13), .DEPTH(8)) if8 ();
    call_stack_if #(.ADDR_W(13), .DEPTH(5)) if5 ();

    call_stack #(.ADDR_W(13), .DEPTH(8)) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (if8.slave)
    );

    call_stack #(.ADDR_W(13), .DEPTH(5)) u_dut5 (
        .clk   (clk),
        .reset (reset),
        .bus   (if5.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op8(input logic psh, input logic [12:0] addr, input logic pp, input logic clr);
        if8.push = psh; if8.push_addr = addr; if8.pop = pp; if8.err_clr = clr;
        @(posedge clk); #1;
        if8.push = 1'b0; if8.push_addr = '0; if8.pop = 1'b0; if8.err_clr = 1'b0;
    endtask

    task automatic op5(input logic psh, input logic [12:0] addr, input logic pp);
        if5.push = psh; if5.push_addr = addr; if5.pop = pp; if5.err_clr = 1'b0;
        @(posedge clk); #1;
        if5.push = 1'b0; if5.push_addr = '0; if5.pop = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        if8.push = 1'b0; if8.push_addr = '0; if8.pop = 1'b0; if8.err_clr = 1'b0;
        if5.push = 1'b0; if5.push_addr = '0; if5.pop = 1'b0; if5.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pop_addr", 32'(if8.pop_addr), 32'h0);
        check("rst_pop_valid", 32'(if8.pop_valid), 32'h0);
        check("rst_level", 32'(if8.level), 32'h0);
        check("rst_empty", 32'(if8.empty), 32'h1);
        check("rst_full", 32'(if8.full), 32'h0);
        check("rst_flags", 32'({if8.overflow, if8.underflow}), 32'h0);
        reset = 1'b0;
        op8(0, 0, 0, 0);

        // LIFO order with back-to-back pops
        op8(1, 13'h0010, 0, 0);
        op8(1, 13'h0020, 0, 0);
        op8(1, 13'h0030, 0, 0);
        check("lifo_level", 32'(if8.level), 32'h3);
        check("lifo_top", 32'(if8.top), 32'h0030);
        op8(0, 0, 1, 0);
        check("pop0_addr", 32'(if8.pop_addr), 32'h0030);
        check("pop0_valid", 32'(if8.pop_valid), 32'h1);
        check("pop0_level", 32'(if8.level), 32'h2);
        op8(0, 0, 1, 0);
        check("pop1_addr", 32'(if8.pop_addr), 32'h0020);
        check("pop1_valid", 32'(if8.pop_valid), 32'h1);
        op8(0, 0, 1, 0);
        check("pop2_addr", 32'(if8.pop_addr), 32'h0010);
        check("pop2_valid", 32'(if8.pop_valid), 32'h1);
        check("pop2_empty", 32'(if8.empty), 32'h1);
        op8(0, 0, 0, 0);
        check("idle_valid", 32'(if8.pop_valid), 32'h0);
        check("idle_hold", 32'(if8.pop_addr), 32'h0010);

        // Underflow and clear priority
        op8(0, 0, 1, 0);
        check("uf_set", 32'(if8.underflow), 32'h1);
        check("uf_valid", 32'(if8.pop_valid), 32'h0);
        check("uf_level", 32'(if8.level), 32'h0);
        check("uf_hold", 32'(if8.pop_addr), 32'h0010);
        op8(0, 0, 0, 1);
        check("uf_clr", 32'(if8.underflow), 32'h0);
        op8(0, 0, 1, 1);
        check("uf_set_wins", 32'(if8.underflow), 32'h1);
        op8(0, 0, 0, 1);
        check("uf_clr2", 32'(if8.underflow), 32'h0);

        // Fill then push while full
        for (int i = 0; i < 8; i++) op8(1, 13'(32'h100 + i), 0, 0);
        check("fill_full", 32'(if8.full), 32'h1);
        check("fill_level", 32'(if8.level), 32'h8);
        check("fill_of", 32'(if8.overflow), 32'h0);
        op8(1, 13'h0108, 0, 0);
        check("of_set", 32'(if8.overflow), 32'h1);
        check("of_level", 32'(if8.level), 32'h8);
        for (int i = 0; i < 8; i++) begin
            op8(0, 0, 1, 0);
`ifdef CALL_STACK_WRAP_EN
            check("of_drain", 32'(if8.pop_addr), 32'h108 - 32'(i));
`else
            check("of_drain", 32'(if8.pop_addr), 32'h107 - 32'(i));
`endif
        end
        check("of_drain_empty", 32'(if8.empty), 32'h1);
        op8(0, 0, 0, 1);
        check("of_clr", 32'(if8.overflow), 32'h0);

        // Return-then-call with entries present
        op8(1, 13'h0999, 0, 0);
        op8(1, 13'h0AAA, 0, 0);
        check("rc_top_pre", 32'(if8.top), 32'h0AAA);
        op8(1, 13'h0BBB, 1, 0);
        check("rc_pop_addr", 32'(if8.pop_addr), 32'h0AAA);
        check("rc_valid", 32'(if8.pop_valid), 32'h1);
        check("rc_level", 32'(if8.level), 32'h2);
        check("rc_top", 32'(if8.top), 32'h0BBB);
        op8(0, 0, 1, 0);
        op8(0, 0, 1, 0);
        check("rc_drain", 32'(if8.pop_addr), 32'h0999);

        // Bypass on empty stack
        op8(1, 13'h1FFF, 1, 0);
        check("byp_addr", 32'(if8.pop_addr), 32'h1FFF);
        check("byp_valid", 32'(if8.pop_valid), 32'h1);
        check("byp_level", 32'(if8.level), 32'h0);
        check("byp_flags", 32'({if8.overflow, if8.underflow}), 32'h0);

        // Push+pop while full raises no overflow
        for (int i = 0; i < 8; i++) op8(1, 13'(32'h200 + i), 0, 0);
        op8(1, 13'h02FF, 1, 0);
        check("fpp_addr", 32'(if8.pop_addr), 32'h0207);
        check("fpp_of", 32'(if8.overflow), 32'h0);
        check("fpp_level", 32'(if8.level), 32'h8);
        check("fpp_top", 32'(if8.top), 32'h02FF);
        for (int i = 0; i < 8; i++) op8(0, 0, 1, 0);
        check("fpp_last", 32'(if8.pop_addr), 32'h0200);

        // DEPTH 5: pointer wrap with a non-power-of-two depth
        for (int i = 0; i < 12; i++) op5(1, 13'(32'h500 + i), 0);
        check("d5_level", 32'(if5.level), 32'h5);
        check("d5_of", 32'(if5.overflow), 32'h1);
        for (int i = 0; i < 5; i++) begin
            op5(0, 0, 1);
`ifdef CALL_STACK_WRAP_EN
            check("d5_drain", 32'(if5.pop_addr), 32'h50B - 32'(i));
`else
            check("d5_drain", 32'(if5.pop_addr), 32'h504 - 32'(i));
`endif
        end
        check("d5_empty", 32'(if5.empty), 32'h1);
        op5(1, 13'h0600, 0);
        op5(1, 13'h0601, 0);
        op5(1, 13'h0602, 0);
        op5(0, 0, 1);
        check("d5_mid_pop", 32'(if5.pop_addr), 32'h0602);
        op5(1, 13'h0603, 0);
        op5(1, 13'h0604, 0);
        op5(1, 13'h0605, 0);
        check("d5_full2", 32'(if5.full), 32'h1);
        op5(0, 0, 1); check("d5_p0", 32'(if5.pop_addr), 32'h0605);
        op5(0, 0, 1); check("d5_p1", 32'(if5.pop_addr), 32'h0604);
        op5(0, 0, 1); check("d5_p2", 32'(if5.pop_addr), 32'h0603);
        op5(0, 0, 1); check("d5_p3", 32'(if5.pop_addr), 32'h0601);
        op5(0, 0, 1); check("d5_p4", 32'(if5.pop_addr), 32'h0600);

        // Asynchronous reset between edges
        op8(1, 13'h0123, 0, 0);
        op8(1, 13'h0124, 0, 0);
        op8(0, 0, 1, 0);
        check("ar_pre_valid", 32'(if8.pop_valid), 32'h1);
        check("ar_pre_level", 32'(if8.level), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("ar_valid", 32'(if8.pop_valid), 32'h0);
        check("ar_addr", 32'(if8.pop_addr), 32'h0);
        check("ar_level", 32'(if8.level), 32'h0);
        check("ar_empty", 32'(if8.empty), 32'h1);
        check("ar_d5_flags", 32'({if5.overflow, if5.underflow}), 32'h0);
        #1 reset = 1'b0;
        op8(0, 0, 0, 0);
        check("ar_after", 32'(if8.level), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
